quan_deskew_psum_v1: RTL and testbench
======================================

QUAN_DESKEW_PSUM_V1 -- requirements
Module: quan_deskew_psum_v1

Interface
REQ-001 SHALL have parameter column_num_in_sa, default 16: number of systolic-array columns (output lanes), N.
REQ-002 SHALL have parameter psum_width, default 32: bits per partial-sum lane, W.
REQ-003 SHALL have parameter pixels_in_row, default 32: valid output vectors per output row, P.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: synchronous clear of the pixel counter.
REQ-007 SHALL have port psum_in, input, N*W: skewed lane sums; lane k occupies bits [k*W +: W].
REQ-008 SHALL have port psum_valid_in, input, 1: qualifies lane 0 of a vector in the current cycle.
REQ-009 SHALL have port psum_out, output, N*W: the de-skewed vector, with the same lane order.
REQ-010 SHALL have port psum_valid_out, output, 1: psum_out holds an aligned vector.
REQ-011 SHALL have port pix_idx, output, clog2(P): index of the current output vector within the row.
REQ-012 SHALL have port row_last, output, 1: psum_valid_out is high for the P-th vector of the row.

Function
REQ-013 SHALL treat lane k of vector v as arriving k cycles after lane 0 of vector v; the arrival time of lane 0 is t0, the cycle in which psum_valid_in is high.
REQ-014 SHALL delay lane k by N-k registered stages, so all lanes of v appear together on psum_out at cycle t0+N.
REQ-015 SHALL use one register for lane N-1; no lane SHALL have a combinational path to psum_out.
REQ-016 SHALL shift the lane delay lines every cycle without gating.
REQ-017 SHALL ignore psum_out content whenever psum_valid_out is low.
REQ-018 SHALL carry psum_valid_in through an N-stage valid pipeline; psum_valid_out SHALL equal psum_valid_in delayed by exactly N cycles.
REQ-019 SHALL support back-to-back vectors (psum_valid_in high on consecutive cycles) at one vector per cycle, without bubbles or lane mixing.
REQ-020 SHALL count valid output vectors in a pixel counter with range 0..P-1; pix_idx SHALL equal the counter value for the vector currently on psum_out.
REQ-021 SHALL assert row_last for exactly the cycle in which psum_valid_out is high and pix_idx equals P-1.
REQ-022 SHALL wrap the pixel counter to 0 on the valid vector after index P-1; there SHALL be no overflow flag.
REQ-023 SHALL make start, sampled in cycle t, give the next valid output at or after t+1 a pix_idx of 0.
REQ-024 SHALL discard the advance that a valid output in cycle t would otherwise cause, when start is high in cycle t.
REQ-025 SHALL leave the valid pipeline and lane data unaffected by start.
REQ-026 SHALL hold pix_idx at its value, and keep row_last low, while psum_valid_out is low.

Reset
REQ-027 SHALL clear on rst: all lane delay registers, psum_out, psum_valid_out, pix_idx and row_last (all 0).
REQ-028 SHALL discard every vector in flight on reset; no psum_valid_out SHALL appear for inputs accepted before or during the rst cycle.
REQ-029 SHALL give rst priority over start and psum_valid_in in the same cycle.
REQ-030 SHALL accept psum_valid_in in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the defaults for N, W and P in the shared quan accelerator parameter package, alongside the values the skew side uses.
REQ-032 SHALL use one sub-module, quan_lane_delay_line, with parameters DEPTH and W; it is instantiated per lane through a generate loop with DEPTH = N-k.
REQ-033 SHALL implement the valid pipeline and the pixel counter in the top level.

Verification
REQ-034 SHALL cover: with N=16, W=32, one vector where lane k = 0x100+k is driven at t0+k and valid is pulsed at t0 -> psum_valid_out high at t0+16 only, and psum_out lane k = 0x100+k.
REQ-035 SHALL cover: 40 back-to-back vectors where lane k of vector v = v*16+k -> 40 consecutive valid outputs with correct lanes, pix_idx 0..31 then 0..7, and row_last high at pixel 31 only.
REQ-036 SHALL cover: gapped input (valid every 3rd cycle, 5 vectors) -> outputs spaced 3 cycles apart, pix_idx 0..4, and pix_idx held between outputs.
REQ-037 SHALL cover: rst asserted 5 cycles after 2 vectors entered -> no psum_valid_out for those vectors, all outputs 0, and a vector entered after reset emerges at pix_idx 0.
REQ-038 SHALL cover: start pulsed in the same cycle as the output with pix_idx 10 -> that output shows 10, the next valid output shows 0, and row_last comes 32 outputs later.
REQ-039 SHALL cover: rst and start high together with psum_valid_in high -> reset behaviour only, and the input is not emitted.

Source files
------------

// File: rtl/quan_deskew_psum_v1_pkg.sv
// Shared quan accelerator parameters: systolic-array geometry used by both
// the skew (input) side and the de-skew (output) side, plus a small helper.
package quan_deskew_psum_v1_pkg;

   // Systolic-array geometry
   localparam int unsigned QUAN_SA_COLS     = 16;
   localparam int unsigned QUAN_SA_ROWS     = 16;
   localparam int unsigned QUAN_PSUM_W      = 32;
   localparam int unsigned QUAN_PIX_PER_ROW = 32;

   // Skew side: activation width and the deepest input skew stage
   localparam int unsigned QUAN_ACT_W       = 8;
   localparam int unsigned QUAN_SKEW_DEPTH  = QUAN_SA_ROWS - 1;

   // Width of an index over n items, never narrower than one bit
   function automatic int unsigned quan_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : quan_deskew_psum_v1_pkg

// File: rtl/quan_deskew_psum_v1_lane_delay_line.sv
// quan_lane_delay_line: fixed-depth, ungated shift register for one lane.
//   clk    : rising-edge clock
//   rst    : synchronous active-high clear of every stage
//   din_i  : lane input, W bits
//   dout_o : lane input delayed by DEPTH cycles (last stage is a register)
module quan_lane_delay_line
   import quan_deskew_psum_v1_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = QUAN_PSUM_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o
);

   logic [W-1:0] stage_q [DEPTH];

   // Shift every cycle; stage 0 captures the lane input
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule : quan_lane_delay_line

// File: rtl/quan_deskew_psum_v1.sv
// quan_deskew_psum_v1: re-aligns the skewed partial sums leaving a systolic
// array. Lane k arrives k cycles after lane 0 and is delayed N-k cycles, so
// every lane of a vector appears together N cycles after its valid pulse.
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset (priority over all inputs)
//   start          : clears the pixel counter
//   psum_in        : N lanes of W bits, lane k at [k*W +: W], skewed
//   psum_valid_in  : marks lane 0 of a vector in this cycle
//   psum_out       : de-skewed vector, same lane order
//   psum_valid_out : psum_out holds an aligned vector
//   pix_idx        : index of the current output vector within its row
//   row_last       : high with the last (P-th) vector of a row
module quan_deskew_psum_v1
   import quan_deskew_psum_v1_pkg::*;
#(
   parameter  int unsigned column_num_in_sa = QUAN_SA_COLS,
   parameter  int unsigned psum_width       = QUAN_PSUM_W,
   parameter  int unsigned pixels_in_row    = QUAN_PIX_PER_ROW,
   localparam int unsigned IdxW             = quan_idx_width(pixels_in_row)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [column_num_in_sa*psum_width-1:0] psum_in,
   input  logic                                   psum_valid_in,
   output logic [column_num_in_sa*psum_width-1:0] psum_out,
   output logic                                   psum_valid_out,
   output logic [IdxW-1:0]                        pix_idx,
   output logic                                   row_last
);

   localparam int unsigned N = column_num_in_sa;
   localparam int unsigned W = psum_width;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(pixels_in_row - 1);

   // Lane delay lines: lane k gets N-k stages, lane N-1 a single register
   for (genvar k = 0; k < int'(N); k++) begin : g_lane
      quan_lane_delay_line #(
         .DEPTH (N - k),
         .W     (W)
      ) u_dly (
         .clk    (clk),
         .rst    (rst),
         .din_i  (psum_in[k*W +: W]),
         .dout_o (psum_out[k*W +: W])
      );
   end

   logic [N-1:0]    vld_q, vld_d;
   logic [IdxW-1:0] ctr_q, ctr_d;
   logic [IdxW-1:0] pix_idx_q, pix_idx_d;
   logic            row_last_q, row_last_d;

   // ctr_q is the index the next valid output will carry. pix_idx/row_last
   // are loaded one edge early (when the stage feeding psum_valid_out is set)
   // so they line up with the vector on psum_out and stay registered.
   always_comb begin
      vld_d      = '0;
      ctr_d      = ctr_q;
      pix_idx_d  = pix_idx_q;
      row_last_d = 1'b0;

      vld_d[0] = psum_valid_in;
      for (int i = 1; i < int'(N); i++) vld_d[i] = vld_q[i-1];

      // start overrides the advance caused by an output in the same cycle
      if (start) begin
         ctr_d = '0;
      end else if (psum_valid_out) begin
         ctr_d = (ctr_q == IdxLast) ? '0 : ctr_q + IdxW'(1);
      end

      if (vld_d[N-1]) begin
         pix_idx_d  = ctr_d;
         row_last_d = (ctr_d == IdxLast);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         ctr_q      <= '0;
         pix_idx_q  <= '0;
         row_last_q <= 1'b0;
      end else begin
         vld_q      <= vld_d;
         ctr_q      <= ctr_d;
         pix_idx_q  <= pix_idx_d;
         row_last_q <= row_last_d;
      end
   end

   assign psum_valid_out = vld_q[N-1];
   assign pix_idx        = pix_idx_q;
   assign row_last       = row_last_q;

endmodule : quan_deskew_psum_v1

// File: tb/tb_quan_deskew_psum_v1.sv
// Self-checking bench for quan_deskew_psum_v1 (N=16, W=32, P=32).
module tb_quan_deskew_psum_v1;

   localparam int N  = 16;
   localparam int W  = 32;
   localparam int P  = 32;
   localparam int IW = 5;

   logic             clk;
   logic             rst;
   logic             start;
   logic [N*W-1:0]   psum_in;
   logic             psum_valid_in;
   logic [N*W-1:0]   psum_out;
   logic             psum_valid_out;
   logic [IW-1:0]    pix_idx;
   logic             row_last;

   quan_deskew_psum_v1 #(
      .column_num_in_sa (N),
      .psum_width       (W),
      .pixels_in_row    (P)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .psum_in        (psum_in),
      .psum_valid_in  (psum_valid_in),
      .psum_out       (psum_out),
      .psum_valid_out (psum_valid_out),
      .pix_idx        (pix_idx),
      .row_last       (row_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           v;
      logic [N*W-1:0] d;
      logic [IW-1:0]  idx;
      logic           last;
      int             cyc;
   } obs_t;

   int             n_cmp = 0;
   int             n_err = 0;
   int             cyc   = 0;
   logic [N*W-1:0] exp_q [$];
   obs_t           trace [$];
   logic [N*W-1:0] hist [N];

   function automatic logic [N*W-1:0] make_vec(input int base);
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = W'(base + k);
      return r;
   endfunction

   function automatic logic [N*W-1:0] rand_vec();
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
      return r;
   endfunction

   // One clock: lane k carries the vector launched k cycles ago; the
   // expected vector is queued at launch, outputs are sampled 1ns after the edge.
   task automatic drive_cycle(input bit v, input logic [N*W-1:0] vec,
                              input bit st, input bit r);
      obs_t o;
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = vec;
      for (int k = 0; k < N; k++) psum_in[k*W +: W] = hist[k][k*W +: W];
      psum_valid_in = v;
      start         = st;
      rst           = r;
      if (v && !r) exp_q.push_back(vec);
      @(posedge clk);
      #1;
      cyc++;
      o.v    = psum_valid_out;
      o.d    = psum_out;
      o.idx  = pix_idx;
      o.last = row_last;
      o.cyc  = cyc;
      trace.push_back(o);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      obs_t o;
      int   nv;
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, make_vec(5), 1'b0, 1'b1);
      o = trace[$];
      n_cmp++; if (o.v !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o.v); end
      n_cmp++; if (o.d !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", o.d); end
      n_cmp++; if (o.idx !== '0) begin n_err++; $display("FAIL reset_idx got %0d want 0", o.idx); end
      n_cmp++; if (o.last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", o.last); end
      exp_q.delete();
      trace.delete();
      idle(N + 3);
      nv = 0;
      foreach (trace[i]) if (trace[i].v) nv++;
      n_cmp++; if (nv != 0) begin n_err++; $display("FAIL reset_no_output got %0d want 0", nv); end
   endtask

   task automatic test_single();
      int t0, nv;
      logic [N*W-1:0] e;
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      trace.delete(); exp_q.delete();
      t0 = cyc;
      drive_cycle(1'b1, make_vec(32'h100), 1'b0, 1'b0);
      idle(N + 4);
      nv = 0;
      foreach (trace[i]) begin
         if (trace[i].v) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++; if (trace[i].cyc != t0 + N) begin n_err++; $display("FAIL single_time got %0d want %0d", trace[i].cyc, t0 + N); end
            n_cmp++; if (trace[i].d !== e) begin n_err++; $display("FAIL single_data got %h want %h", trace[i].d, e); end
            n_cmp++; if (trace[i].idx !== IW'(0)) begin n_err++; $display("FAIL single_idx got %0d want 0", trace[i].idx); end
            n_cmp++; if (trace[i].last !== 1'b0) begin n_err++; $display("FAIL single_last got %b want 0", trace[i].last); end
            nv++;
         end
      end
      n_cmp++; if (nv != 1) begin n_err++; $display("FAIL single_count got %0d want 1", nv); end
   endtask

   task automatic test_back_to_back();
      int t0, n, ei;
      logic [N*W-1:0] e;
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      trace.delete(); exp_q.delete();
      t0 = cyc;
      for (int v = 0; v < 40; v++) drive_cycle(1'b1, make_vec(v * 16), 1'b0, 1'b0);
      idle(N + 3);
      n = 0;
      foreach (trace[i]) begin
         if (trace[i].v) begin
            ei = n % P;
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra output at cycle %0d", trace[i].cyc); end
            else begin
               e = exp_q.pop_front();
               if (trace[i].d !== e) begin n_err++; $display("FAIL b2b_data v=%0d got %h want %h", n, trace[i].d, e); end
            end
            n_cmp++; if (trace[i].cyc != t0 + N + n) begin n_err++; $display("FAIL b2b_time v=%0d got %0d want %0d", n, trace[i].cyc, t0 + N + n); end
            n_cmp++; if (trace[i].idx !== IW'(ei)) begin n_err++; $display("FAIL b2b_idx v=%0d got %0d want %0d", n, trace[i].idx, ei); end
            n_cmp++; if (trace[i].last !== (ei == P - 1)) begin n_err++; $display("FAIL b2b_last v=%0d got %b want %b", n, trace[i].last, ei == P - 1); end
            n++;
         end else begin
            n_cmp++; if (trace[i].last !== 1'b0) begin n_err++; $display("FAIL b2b_last_idle got %b want 0", trace[i].last); end
         end
      end
      n_cmp++; if (n != 40) begin n_err++; $display("FAIL b2b_count got %0d want 40", n); end
   endtask

   task automatic test_gapped();
      int t0, n;
      logic [N*W-1:0] e;
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      trace.delete(); exp_q.delete();
      t0 = cyc;
      for (int v = 0; v < 5; v++) begin
         drive_cycle(1'b1, rand_vec(), 1'b0, 1'b0);
         idle(2);
      end
      idle(N + 3);
      n = 0;
      foreach (trace[i]) begin
         if (trace[i].v) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++; if (trace[i].d !== e) begin n_err++; $display("FAIL gap_data v=%0d got %h want %h", n, trace[i].d, e); end
            n_cmp++; if (trace[i].cyc != t0 + N + 3 * n) begin n_err++; $display("FAIL gap_time v=%0d got %0d want %0d", n, trace[i].cyc, t0 + N + 3 * n); end
            n_cmp++; if (trace[i].idx !== IW'(n)) begin n_err++; $display("FAIL gap_idx got %0d want %0d", trace[i].idx, n); end
            n++;
         end else if (n > 0) begin
            n_cmp++; if (trace[i].idx !== IW'(n - 1)) begin n_err++; $display("FAIL gap_hold got %0d want %0d", trace[i].idx, n - 1); end
            n_cmp++; if (trace[i].last !== 1'b0) begin n_err++; $display("FAIL gap_last_idle got %b want 0", trace[i].last); end
         end
      end
      n_cmp++; if (n != 5) begin n_err++; $display("FAIL gap_count got %0d want 5", n); end
   endtask

   task automatic test_reset_in_flight();
      obs_t o;
      int   t1, nv;
      logic [N*W-1:0] e;
      trace.delete(); exp_q.delete();
      drive_cycle(1'b1, make_vec(32'h500), 1'b0, 1'b0);
      drive_cycle(1'b1, make_vec(32'h600), 1'b0, 1'b0);
      idle(4);
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      o = trace[$];
      n_cmp++; if (o.v !== 1'b0 || o.d !== '0 || o.idx !== '0 || o.last !== 1'b0) begin
         n_err++; $display("FAIL flight_reset_outputs got v=%b idx=%0d last=%b d=%h want all 0", o.v, o.idx, o.last, o.d);
      end
      exp_q.delete(); trace.delete();
      t1 = cyc;
      drive_cycle(1'b1, make_vec(32'h700), 1'b0, 1'b0);
      idle(N + 3);
      nv = 0;
      foreach (trace[i]) begin
         if (trace[i].v) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++; if (trace[i].cyc != t1 + N) begin n_err++; $display("FAIL flight_time got %0d want %0d", trace[i].cyc, t1 + N); end
            n_cmp++; if (trace[i].d !== e) begin n_err++; $display("FAIL flight_data got %h want %h", trace[i].d, e); end
            n_cmp++; if (trace[i].idx !== IW'(0)) begin n_err++; $display("FAIL flight_idx got %0d want 0", trace[i].idx); end
            nv++;
         end
      end
      n_cmp++; if (nv != 1) begin n_err++; $display("FAIL flight_count got %0d want 1", nv); end
   endtask

   task automatic test_start();
      int t0, n, ei, nlast;
      logic [N*W-1:0] e;
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      trace.delete(); exp_q.delete();
      t0 = cyc;
      // output of vector 10 is on psum_out during cycle t0+10+N
      for (int i = 0; i < 45 + N + 3; i++)
         drive_cycle(i < 45, make_vec(32'h1000 + i * 16), i == 10 + N, 1'b0);
      n = 0; nlast = 0;
      foreach (trace[i]) begin
         if (trace[i].v) begin
            ei = (n <= 10) ? n : (n - 11) % P;
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++; if (trace[i].d !== e) begin n_err++; $display("FAIL start_data v=%0d got %h want %h", n, trace[i].d, e); end
            n_cmp++; if (trace[i].idx !== IW'(ei)) begin n_err++; $display("FAIL start_idx v=%0d got %0d want %0d", n, trace[i].idx, ei); end
            n_cmp++; if (trace[i].last !== (n == 42)) begin n_err++; $display("FAIL start_last v=%0d got %b want %b", n, trace[i].last, n == 42); end
            if (trace[i].last) nlast++;
            n++;
         end
      end
      n_cmp++; if (n != 45) begin n_err++; $display("FAIL start_count got %0d want 45", n); end
      n_cmp++; if (nlast != 1) begin n_err++; $display("FAIL start_rowlast_count got %0d want 1", nlast); end
   endtask

   task automatic test_rst_start();
      obs_t o;
      int   t1, nv;
      trace.delete(); exp_q.delete();
      drive_cycle(1'b1, make_vec(32'h900), 1'b1, 1'b1);
      o = trace[$];
      n_cmp++; if (o.v !== 1'b0 || o.d !== '0 || o.idx !== '0 || o.last !== 1'b0) begin
         n_err++; $display("FAIL rststart_outputs got v=%b idx=%0d last=%b want all 0", o.v, o.idx, o.last);
      end
      trace.delete();
      idle(N + 3);
      nv = 0;
      foreach (trace[i]) if (trace[i].v) nv++;
      n_cmp++; if (nv != 0) begin n_err++; $display("FAIL rststart_emitted got %0d want 0", nv); end
      trace.delete(); exp_q.delete();
      t1 = cyc;
      drive_cycle(1'b1, make_vec(32'hA00), 1'b0, 1'b0);
      idle(N + 2);
      nv = 0;
      foreach (trace[i]) begin
         if (trace[i].v) begin
            n_cmp++; if (trace[i].cyc != t1 + N || trace[i].idx !== IW'(0)) begin
               n_err++; $display("FAIL rststart_after got cyc=%0d idx=%0d want cyc=%0d idx=0", trace[i].cyc, trace[i].idx, t1 + N);
            end
            nv++;
         end
      end
      n_cmp++; if (nv != 1) begin n_err++; $display("FAIL rststart_after_count got %0d want 1", nv); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; psum_valid_in = 1'b0; psum_in = '0;
      for (int k = 0; k < N; k++) hist[k] = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_gapped();
      test_reset_in_flight();
      test_start();
      test_rst_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule : tb_quan_deskew_psum_v1
